sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO that succeeds the dual-clock 4-bit FIFO on the Tiny Tapeout tile. It is generalised in width, depth and flag thresholds and adds:
- an occupancy count,
- almost-full and almost-empty flags,
- sticky overflow and underflow error flags,
- a selectable first-word-fall-through (FWFT) read mode.

It buffers data between the tile's input pins and output logic when both sides run on the tile `clk`.

---
 rtl/sync_fifo_flags.sv | 125 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow errors and an optional first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH          = 4,
    parameter int unsigned ADDRESS_WIDTH       = 5,
    parameter int unsigned ALMOST_FULL_MARGIN  = 4,
    parameter int unsigned ALMOST_EMPTY_MARGIN = 4,
    parameter bit          FWFT                = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_increment,
    input  logic                     read_increment,
    input  logic                     clear_errors,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    localparam logic [ADDRESS_WIDTH:0]   LEVEL_ONE  = (ADDRESS_WIDTH + 1)'(1);
    localparam logic [ADDRESS_WIDTH:0]   LEVEL_FULL = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   AF_THRESH  =
        (ADDRESS_WIDTH + 1)'(DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [ADDRESS_WIDTH:0]   AE_THRESH  =
        (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_MARGIN);
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE    = ADDRESS_WIDTH'(1);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_WIDTH:0]   level_q, level_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;
    logic                     wr_accept, rd_accept;

    // Flags come only from the registered level, never from the request inputs.
    assign empty        = (level_q == '0);
    assign full         = (level_q == LEVEL_FULL);
    assign almost_full  = (level_q >= AF_THRESH);
    assign almost_empty = (level_q <= AE_THRESH);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_accept = write_increment && !full;
    assign rd_accept = read_increment && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;

        unique case ({wr_accept, rd_accept})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        // A new error in the same cycle as a clear wins.
        if (write_increment && !wr_accept) begin
            overflow_d = 1'b1;
        end else if (clear_errors) begin
            overflow_d = 1'b0;
        end

        if (read_increment && !rd_accept) begin
            underflow_d = 1'b1;
        end else if (clear_errors) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q] <= write_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign read_data = mem[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] read_data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    read_data_q <= '0;
                end else if (rd_accept) begin
                    read_data_q <= mem[rd_ptr_q];
                end
            end

            assign read_data = read_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-read and an FWFT instance with the same stimulus and checks both
// against a queue-based model of the FIFO.
module tb_sync_fifo_flags;

    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AFM   = 4;
    localparam int AEM   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          write_increment = 1'b0;
    logic          read_increment = 1'b0;
    logic          clear_errors = 1'b0;

    logic [DW-1:0] s_rd, f_rd;
    logic          s_empty, s_ae, s_full, s_af, s_ov, s_uf;
    logic          f_empty, f_ae, f_full, f_af, f_ov, f_uf;
    logic [AW:0]   s_level, f_level;

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_MARGIN(AFM),
        .ALMOST_EMPTY_MARGIN(AEM), .FWFT(1'b0)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .write_data(write_data),
        .write_increment(write_increment), .read_increment(read_increment),
        .clear_errors(clear_errors), .read_data(s_rd), .empty(s_empty),
        .almost_empty(s_ae), .full(s_full), .almost_full(s_af), .level(s_level),
        .overflow(s_ov), .underflow(s_uf)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_MARGIN(AFM),
        .ALMOST_EMPTY_MARGIN(AEM), .FWFT(1'b1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .write_data(write_data),
        .write_increment(write_increment), .read_increment(read_increment),
        .clear_errors(clear_errors), .read_data(f_rd), .empty(f_empty),
        .almost_empty(f_ae), .full(f_full), .almost_full(f_af), .level(f_level),
        .overflow(f_ov), .underflow(f_uf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: contents as a queue, errors as plain bits.
    logic [DW-1:0] q[$];
    bit            m_ov = 1'b0;
    bit            m_uf = 1'b0;
    logic [DW-1:0] m_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int lvl;
        lvl = q.size();
        check_eq("s_level", 32'(s_level), 32'(lvl));
        check_eq("s_empty", 32'(s_empty), 32'(lvl == 0));
        check_eq("s_full", 32'(s_full), 32'(lvl == DEPTH));
        check_eq("s_af", 32'(s_af), 32'(lvl >= DEPTH - AFM));
        check_eq("s_ae", 32'(s_ae), 32'(lvl <= AEM));
        check_eq("s_ov", 32'(s_ov), 32'(m_ov));
        check_eq("s_uf", 32'(s_uf), 32'(m_uf));
        check_eq("s_rd", 32'(s_rd), 32'(m_rd));
        check_eq("f_level", 32'(f_level), 32'(lvl));
        check_eq("f_empty", 32'(f_empty), 32'(lvl == 0));
        check_eq("f_full", 32'(f_full), 32'(lvl == DEPTH));
        check_eq("f_af", 32'(f_af), 32'(lvl >= DEPTH - AFM));
        check_eq("f_ae", 32'(f_ae), 32'(lvl <= AEM));
        check_eq("f_ov", 32'(f_ov), 32'(m_ov));
        check_eq("f_uf", 32'(f_uf), 32'(m_uf));
        if (lvl > 0) check_eq("f_rd_head", 32'(f_rd), 32'(q[0]));
    endtask

    // One clock of stimulus; the model applies the FIFO rules to the pre-edge contents.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
        bit acc_w, acc_r;
        write_increment = wr;
        write_data      = d;
        read_increment  = rd;
        clear_errors    = clr;
        @(posedge clk);
        acc_w = wr && (q.size() < DEPTH);
        acc_r = rd && (q.size() > 0);
        if (acc_r) m_rd = q.pop_front();
        if (acc_w) q.push_back(d);
        m_ov = (wr && !acc_w) ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_uf = (rd && !acc_r) ? 1'b1 : (clr ? 1'b0 : m_uf);
        #1;
        write_increment = 1'b0;
        read_increment  = 1'b0;
        clear_errors    = 1'b0;
        check_all();
    endtask

    initial begin
        // Reset held, then released on a falling edge.
        #23;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_rd", 32'(s_rd), 32'h0);
        check_all();

        // Fill with i mod 16 and probe the threshold crossings.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DW'((i - 1) % 16), 1'b0, 1'b0);
            if (i == 4) check_eq("ae_at4", 32'(s_ae), 32'h1);
            if (i == 5) check_eq("ae_at5", 32'(s_ae), 32'h0);
            if (i == 27) check_eq("af_at27", 32'(s_af), 32'h0);
            if (i == 28) check_eq("af_at28", 32'(s_af), 32'h1);
            if (i == 32) check_eq("full_lvl", 32'(s_level), 32'd32);
        end
        step(1'b1, 4'hF, 1'b0, 1'b0);
        check_eq("ovf_set", 32'(s_ov), 32'h1);
        check_eq("ovf_lvl", 32'(s_level), 32'd32);

        // Drain: data in order, one cycle after each read.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check_eq("drain_rd", 32'(s_rd), 32'(i % 16));
        end
        step(1'b0, '0, 1'b1, 1'b1);
        check_eq("udf_set", 32'(s_uf), 32'h1);
        check_eq("udf_hold", 32'(s_rd), 32'd15);
        check_eq("ovf_clr", 32'(s_ov), 32'h0);

        // Both requests at empty.
        step(1'b1, 4'hA, 1'b1, 1'b1);
        check_eq("both_empty_lvl", 32'(s_level), 32'd1);
        check_eq("both_empty_uf", 32'(s_uf), 32'h1);
        check_eq("fwft_head_A", 32'(f_rd), 32'hA);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("fwft_next_5", 32'(f_rd), 32'h5);

        // Both requests at level 10.
        while (q.size() < 10) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        check_eq("both_mid_lvl", 32'(s_level), 32'd10);

        // Both requests at full.
        while (q.size() < DEPTH) step(1'b1, DW'($urandom), 1'b0, 1'b1);
        step(1'b1, DW'($urandom), 1'b1, 1'b0);
        check_eq("both_full_lvl", 32'(s_level), 32'd31);
        check_eq("both_full_ov", 32'(s_ov), 32'h1);

        // Randomised traffic with pointer wrap and occasional clears.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end

        // Clear together with a new rejected read: set wins.
        while (q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check_eq("clr_vs_udf", 32'(s_uf), 32'h1);

        // Asynchronous reset at level 7.
        for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        check_eq("pre_rst_lvl", 32'(s_level), 32'd7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ov = 1'b0;
        m_uf = 1'b0;
        m_rd = '0;
        check_eq("arst_lvl", 32'(s_level), 32'd0);
        check_eq("arst_empty", 32'(f_empty), 32'h1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Short post-reset run to confirm normal operation resumes.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
